// File: rtl/serial_link_peer_if.sv
// Byte-wide host handshake of serial_link_peer: the host loads a byte to send
// and collects the byte received from the DMG.
interface serial_link_peer_if;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;

   modport master (
      output tx_data,
      output tx_valid,
      input  tx_ready,
      input  rx_data,
      input  rx_valid
   );

   modport slave (
      input  tx_data,
      input  tx_valid,
      output tx_ready,
      output rx_data,
      output rx_valid
   );
endinterface

// File: rtl/serial_link_peer.sv
// serial_link_peer: far-end partner of the DMG link port, one byte per transfer, SCK slave or master.
// Optional slave inactivity abort is compiled in with `define SERIAL_PEER_TIMEOUT_EN.
module serial_link_peer #(
   parameter int CLK_DIV_HALF   = 64,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic              clk,
   input  logic              nreset,
   input  logic              master,
   serial_link_peer_if.slave bus,
   output logic              busy,
   input  logic              link_sck_in,
   input  logic              link_sin,
   output logic              link_sout,
   output logic              link_sck_out,
   output logic              link_sck_oe,
   output logic              timeout
);

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      SLAVE_XFER = 2'd1,
      MASTER_HI  = 2'd2,
      MASTER_LO  = 2'd3
   } state_t;

   localparam int DIV_W = $clog2(CLK_DIV_HALF);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV_HALF - 1);

   state_t           state;
   state_t           state_nxt;
   logic [7:0]       sr;
   logic [3:0]       cnt;
   logic             armed;
   logic [DIV_W-1:0] div;

   logic sck_p0, sck_p1, sck_p2;
   logic sin_p0, sin_p1;
   logic sin_sync;
   logic fall, rise;
   logic load, div_done, shift_ev, drive_ev, last_bit, abort;

   function automatic logic [7:0] shift_in(input logic [7:0] v, input logic b);
      return {v[6:0], b};
   endfunction

   // stage p0/p1: two-flop synchronizers; p2: SCK edge detect
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         sck_p0 <= 1'b1;
         sck_p1 <= 1'b1;
         sck_p2 <= 1'b1;
         sin_p0 <= 1'b1;
         sin_p1 <= 1'b1;
      end else begin
         sck_p0 <= link_sck_in;
         sck_p1 <= sck_p0;
         sck_p2 <= sck_p1;
         sin_p0 <= link_sin;
         sin_p1 <= sin_p0;
      end
   end

   assign sin_sync = sin_p1;
   assign fall     = sck_p2 & ~sck_p1;
   assign rise     = ~sck_p2 & sck_p1;

   assign load     = bus.tx_valid && (state == IDLE) && !armed;
   assign div_done = (div == DIV_LAST);
   assign shift_ev = ((state == SLAVE_XFER) && rise) || ((state == MASTER_LO) && div_done);
   assign drive_ev = (((state == IDLE) || (state == SLAVE_XFER)) && fall) ||
                     ((state == MASTER_HI) && div_done);
   assign last_bit = shift_ev && (cnt == 4'd7);

`ifdef SERIAL_PEER_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

   logic [TO_W-1:0] idle_cnt;

   assign abort = (state == SLAVE_XFER) && !fall && !rise && (idle_cnt == TO_LAST);

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         idle_cnt <= '0;
         timeout  <= 1'b0;
      end else begin
         timeout <= abort;
         if ((state != SLAVE_XFER) || fall || rise) begin
            idle_cnt <= '0;
         end else begin
            idle_cnt <= idle_cnt + 1'b1;
         end
      end
   end
`else
   logic unused_timeout_cfg;

   assign abort              = 1'b0;
   assign timeout            = 1'b0;
   assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (load && master) begin
               state_nxt = MASTER_HI;
            end else if (fall) begin
               state_nxt = SLAVE_XFER;
            end
         end
         SLAVE_XFER: begin
            if (last_bit || abort) begin
               state_nxt = IDLE;
            end
         end
         MASTER_HI: begin
            if (div_done) begin
               state_nxt = MASTER_LO;
            end
         end
         MASTER_LO: begin
            if (div_done) begin
               state_nxt = last_bit ? IDLE : MASTER_HI;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy         = (state != IDLE);
      bus.tx_ready = (state == IDLE) && !armed;
      link_sck_oe  = (state == MASTER_HI) || (state == MASTER_LO);
      link_sck_out = (state != MASTER_LO);
   end

   // A load and an SCK fall in the same IDLE cycle: the new byte's MSB goes out at once.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         sr           <= 8'hFF;
         cnt          <= 4'd0;
         armed        <= 1'b0;
         div          <= '0;
         link_sout    <= 1'b1;
         bus.rx_data  <= 8'h00;
         bus.rx_valid <= 1'b0;
      end else begin
         bus.rx_valid <= 1'b0;

         if ((state == MASTER_HI) || (state == MASTER_LO)) begin
            div <= div_done ? '0 : div + 1'b1;
         end else begin
            div <= '0;
         end

         if (load) begin
            sr    <= bus.tx_data;
            armed <= 1'b1;
            if (!master && fall) begin
               link_sout <= bus.tx_data[7];
            end
         end else begin
            if (drive_ev) begin
               link_sout <= sr[7];
            end
            if (last_bit) begin
               bus.rx_data  <= shift_in(sr, sin_sync);
               bus.rx_valid <= 1'b1;
               sr           <= 8'hFF;
               armed        <= 1'b0;
               cnt          <= 4'd0;
            end else if (shift_ev) begin
               sr  <= shift_in(sr, sin_sync);
               cnt <= cnt + 4'd1;
            end else if (abort) begin
               sr    <= 8'hFF;
               armed <= 1'b0;
               cnt   <= 4'd0;
            end
         end
      end
   end

endmodule
